// File: rtl/ascon_bist_ctrl.sv
// ascon_bist_ctrl: multi-vector, watchdog-protected BIST sequencer for the Ascon AEAD core.
// Runs NUM_VECTORS encrypt-then-decrypt checks, counts auth mismatches and
// watchdog expiries, and reports a single pass/fail verdict.
// Optional feature macro: ASCON_BIST_TAMPER_EN adds a second, tag-corrupted
// pass per vector that must be rejected by the core.
module ascon_bist_ctrl #(
    parameter int NUM_VECTORS    = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int VEC_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
    localparam int CNT_W = $clog2(2*NUM_VECTORS+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_count,
    output logic             timeout,
    output logic             core_start,
    output logic [VEC_W-1:0] core_vec_sel,
    output logic             core_tamper,
    input  logic             core_enc_done,
    input  logic             core_dec_done,
    input  logic             core_auth_ok
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, LAUNCH, WAIT_ENC, WAIT_DEC, CHECK, NEXT, DONE
    } state_t;

    state_t            state, state_d;
    logic [VEC_W-1:0]  vec_idx;
    logic              phase;
    logic              pass_last;
    logic [WD_W-1:0]   wdog;
    logic              auth_q;
    logic              in_wait;
    logic              wd_last;
    logic              last_step;

    // Sequence control strobes from the next-state logic
    logic clr_seq;
    logic cap_auth;
    logic chk_fail;
    logic wd_hit;
    logic step;

    assign in_wait   = (state == WAIT_ENC) || (state == WAIT_DEC);
    assign wd_last   = (wdog == WD_W'(TIMEOUT_CYCLES-1));
    assign last_step = pass_last && (vec_idx == VEC_W'(NUM_VECTORS-1));

`ifdef ASCON_BIST_TAMPER_EN
    // Pass toggles clean -> tampered within each vector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         phase <= 1'b0;
        else if (clr_seq) phase <= 1'b0;
        else if (step)    phase <= ~phase;
    end
    assign pass_last = phase;
`else
    assign phase     = 1'b0;
    assign pass_last = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_d  = state;
        clr_seq  = 1'b0;
        cap_auth = 1'b0;
        chk_fail = 1'b0;
        wd_hit   = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LAUNCH;
                    clr_seq = 1'b1;
                end
            end
            LAUNCH: state_d = WAIT_ENC;
            WAIT_ENC: begin
                if (core_enc_done && core_dec_done) begin
                    state_d  = CHECK;
                    cap_auth = 1'b1;
                end else if (core_enc_done) begin
                    state_d = WAIT_DEC;
                end else if (wd_last) begin
                    state_d = NEXT;
                    wd_hit  = 1'b1;
                end
            end
            WAIT_DEC: begin
                if (core_dec_done) begin
                    state_d  = CHECK;
                    cap_auth = 1'b1;
                end else if (wd_last) begin
                    state_d = NEXT;
                    wd_hit  = 1'b1;
                end
            end
            CHECK: begin
                state_d  = NEXT;
                chk_fail = (auth_q != ~phase);
            end
            NEXT: begin
                step    = 1'b1;
                state_d = last_step ? DONE : LAUNCH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Watchdog: counts while parked in a wait state, zero on any transition
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          wdog <= '0;
        else if (in_wait && state_d == state) wdog <= wdog + 1'b1;
        else                               wdog <= '0;
    end

    // Vector index advances after the final pass of each vector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               vec_idx <= '0;
        else if (clr_seq)                       vec_idx <= '0;
        else if (step && pass_last && !last_step) vec_idx <= vec_idx + 1'b1;
    end

    // Capture the tag-check result alongside dec_done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          auth_q <= 1'b0;
        else if (cap_auth) auth_q <= core_auth_ok;
    end

    // Saturating failure counter: auth mismatches plus watchdog expiries
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                    fail_count <= '0;
        else if (clr_seq)                            fail_count <= '0;
        else if ((chk_fail || wd_hit) && fail_count != '1) fail_count <= fail_count + 1'b1;
    end

    // Sticky watchdog flag for the current sequence
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         timeout <= 1'b0;
        else if (clr_seq) timeout <= 1'b0;
        else if (wd_hit)  timeout <= 1'b1;
    end

    assign busy         = (state != IDLE) && (state != DONE);
    assign done         = (state == DONE);
    assign pass         = done && (fail_count == '0) && !timeout;
    assign core_start   = (state == LAUNCH);
    assign core_vec_sel = vec_idx;
    assign core_tamper  = phase;

endmodule

// File: doc/ascon_bist_ctrl.md
# ascon_bist_ctrl

Built-in self-test sequencer for the Ascon AEAD core. On `start` it runs `NUM_VECTORS` stored test vectors through the core's encrypt-then-decrypt flow, one after another, and checks the authentication result of each. It counts failures, flags timeouts, and reports a single pass/fail verdict. It sits between the top-level test/control logic and the Ascon core, and replaces the single-shot start/done/authenticated check with a parametrised, multi-vector, watchdog-protected sequence.

## Interface
Parameters:
- `NUM_VECTORS`, 4: number of test vectors run per sequence (≥1).
- `TIMEOUT_CYCLES`, 1024: per-phase watchdog limit in clk cycles (≥2).

Derived widths:
- `VEC_W` = max(1, $clog2(NUM_VECTORS)).
- `CNT_W` = $clog2(2*NUM_VECTORS+1).

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  launch a sequence; level sampled per cycle.
- `busy`  output  1  sequence in progress.
- `done`  output  1  sequence complete; held until the next accepted `start`.
- `pass`  output  1  valid while `done`=1; 1 iff `fail_count`=0 and `timeout`=0.
- `fail_count`  output  CNT_W  failed checks in the current or last sequence.
- `timeout`  output  1  sticky; set if any phase hit the watchdog.
- `core_start`  output  1  one-cycle launch pulse to the core.
- `core_vec_sel`  output  VEC_W  vector index presented to the core; stable while `busy`.
- `core_tamper`  output  1  instructs the core to corrupt the tag before decryption.
- `core_enc_done`  input  1  encryption-complete pulse from the core.
- `core_dec_done`  input  1  decryption-complete pulse from the core.
- `core_auth_ok`  input  1  tag-check result; valid in the cycle `core_dec_done`=1.

## Operation
- FSM states: IDLE, LAUNCH, WAIT_ENC, WAIT_DEC, CHECK, NEXT, DONE.
- IDLE/DONE + `start`=1 → LAUNCH. On this transition, clear `fail_count`, `timeout`, the vector index, the pass phase, and `done`.
- LAUNCH: assert `core_start` for exactly 1 cycle, clear the watchdog, then go to WAIT_ENC.
- WAIT_ENC → WAIT_DEC on `core_enc_done`.
  - If `core_enc_done` and `core_dec_done` are both high in the same cycle, go directly to CHECK and capture `core_auth_ok`.
- WAIT_DEC → CHECK on `core_dec_done`, capturing `core_auth_ok` into a register.
- Watchdog: the counter increments each cycle in WAIT_ENC/WAIT_DEC and is cleared on each phase transition. If it reaches `TIMEOUT_CYCLES-1` with no event, the FSM:
  - sets `timeout`,
  - counts one failure,
  - goes to NEXT, skipping CHECK.
- CHECK: expected auth = ~`core_tamper`. A mismatch increments `fail_count`, which saturates at all-ones.
- NEXT: advance to the next pass or vector.
  - If the last pass of the last vector is done, go to DONE.
  - Otherwise go to LAUNCH.
- DONE: `done`=1, `busy`=0. Stay until `start`.
- `busy`=1 in every state except IDLE and DONE. `start` is ignored while `busy`=1.
- Core pulses arriving in IDLE, LAUNCH, CHECK, NEXT or DONE are ignored.

## Timing
- Reset values (async, `rst`=0): state=IDLE; all outputs 0, including `pass`, `fail_count`, `core_vec_sel`, `core_tamper`.
- `start` high in cycle N → `busy`=1 and state=LAUNCH at N+1 → `core_start`=1 at N+1 only.
- Minimum cycles per pass = 4 + enc latency + dec latency (LAUNCH, CHECK, NEXT, plus one WAIT entry).
- `done` and `pass` rise together, 1 cycle after the NEXT that completes the last vector.
- `rst` asserted mid-sequence aborts immediately. No `core_start` is issued after the reset edge.

## Configuration
- Macro `ASCON_BIST_TAMPER_EN`.
- Defined: each vector runs two passes.
  - Pass 0 has `core_tamper`=0 and expects auth=1.
  - Pass 1 has `core_tamper`=1 and expects auth=0.
  - Total checks = 2*NUM_VECTORS.
- Undefined: one pass per vector. `core_tamper` is tied to 0. Total checks = NUM_VECTORS, and `fail_count` ≤ NUM_VECTORS.

## Test plan
With `NUM_VECTORS`=4 and `TIMEOUT_CYCLES`=64:
- Reset with all inputs low → every output 0. Release reset, pulse `start` → `core_start` at the next cycle with `core_vec_sel`=0.
- Core model with enc 10 / dec 10 cycles, auth correct → `core_vec_sel` steps 0,1,2,3; `done`=1, `pass`=1, `fail_count`=0. Sequence count: 4 launches, or 8 launches with TAMPER_EN.
- Model returns auth=0 on vector 2, pass 0 → `fail_count`=1, `pass`=0. With TAMPER_EN: model returns auth=1 on every tampered pass → `fail_count`=4.
- Model never asserts `core_dec_done` on vector 1 → `timeout`=1 after 64 cycles in WAIT_DEC; the sequence continues to vector 2; final `fail_count`=1, `pass`=0.
- `start` pulsed during `busy`, and `core_enc_done` pulsed in IDLE → no extra launch, no state change. `rst`=0 mid-WAIT_ENC → IDLE and outputs 0 immediately.
- Same-cycle `core_enc_done` and `core_dec_done` with auth=1 → CHECK entered directly, no failure counted. A second `start` from DONE → counters clear and `done` drops.
